// File: rtl/ahb_mtx_input_stage_hold.sv
// AHB bus-matrix per-master input stage: passes the live address phase straight through,
// or replays a held copy while the target output stage has not granted the port or is stalled.
module ahb_mtx_input_stage_hold #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned USER_W = 4
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSELS,
   input  logic [ADDR_W-1:0] HADDRS,
   input  logic [USER_W-1:0] HAUSERS,
   input  logic [1:0]        HTRANSS,
   input  logic              HWRITES,
   input  logic [2:0]        HSIZES,
   input  logic [2:0]        HBURSTS,
   input  logic [3:0]        HPROTS,
   input  logic [3:0]        HMASTERS,
   input  logic              HMASTLOCKS,
   input  logic              HREADYS,
   input  logic              active_ip,
   input  logic              readyout_ip,
   input  logic              resp_ip,
   output logic              sel_ip,
   output logic [ADDR_W-1:0] addr_ip,
   output logic [USER_W-1:0] auser_ip,
   output logic [1:0]        trans_ip,
   output logic              write_ip,
   output logic [2:0]        size_ip,
   output logic [2:0]        burst_ip,
   output logic [3:0]        prot_ip,
   output logic [3:0]        master_ip,
   output logic              mastlock_ip,
   output logic              held_tran_ip,
   output logic              HREADYOUTS,
   output logic              HRESPS
);

   logic live_valid;
   logic accept;
   logic pend;
   logic pend_nxt;
   logic dphase;
   logic dphase_nxt;

   logic [ADDR_W-1:0] hold_addr;
   logic [USER_W-1:0] hold_auser;
   logic [1:0]        hold_trans;
   logic              hold_write;
   logic [2:0]        hold_size;
   logic [2:0]        hold_burst;
   logic [3:0]        hold_prot;
   logic [3:0]        hold_master;
   logic              hold_mastlock;

   // Only NONSEQ/SEQ request; IDLE and BUSY never do.
   assign live_valid   = HSELS & HTRANSS[1] & HREADYS;
   assign held_tran_ip = pend | live_valid;
   assign accept       = held_tran_ip & active_ip & readyout_ip;

   // Next-state for the pending-address flag and the downstream data-phase flag.
   always_comb begin
      pend_nxt   = pend & ~accept;
      dphase_nxt = dphase;
      if (live_valid) begin
         pend_nxt = ~accept;
      end
      if (accept) begin
         dphase_nxt = 1'b1;
      end else if (dphase && readyout_ip) begin
         dphase_nxt = 1'b0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pend   <= 1'b0;
         dphase <= 1'b0;
      end else begin
         pend   <= pend_nxt;
         dphase <= dphase_nxt;
      end
   end

   // Capture every requesting address phase so it can be replayed if not accepted.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_addr     <= '0;
         hold_auser    <= '0;
         hold_trans    <= 2'b00;
         hold_write    <= 1'b0;
         hold_size     <= 3'd0;
         hold_burst    <= 3'd0;
         hold_prot     <= 4'd0;
         hold_master   <= 4'd0;
         hold_mastlock <= 1'b0;
      end else if (live_valid) begin
         hold_addr     <= HADDRS;
         hold_auser    <= HAUSERS;
         hold_trans    <= HTRANSS;
         hold_write    <= HWRITES;
         hold_size     <= HSIZES;
         hold_burst    <= HBURSTS;
         hold_prot     <= HPROTS;
         hold_master   <= HMASTERS;
         hold_mastlock <= HMASTLOCKS;
      end
   end

   // Zero-latency pass-through unless a held transfer is pending.
   always_comb begin
      sel_ip      = HSELS;
      addr_ip     = HADDRS;
      auser_ip    = HAUSERS;
      trans_ip    = HTRANSS;
      write_ip    = HWRITES;
      size_ip     = HSIZES;
      burst_ip    = HBURSTS;
      prot_ip     = HPROTS;
      master_ip   = HMASTERS;
      mastlock_ip = HMASTLOCKS;
      if (pend) begin
         sel_ip      = 1'b1;
         addr_ip     = hold_addr;
         auser_ip    = hold_auser;
         trans_ip    = hold_trans;
         write_ip    = hold_write;
         size_ip     = hold_size;
         burst_ip    = hold_burst;
         prot_ip     = hold_prot;
         master_ip   = hold_master;
         mastlock_ip = hold_mastlock;
      end
   end

   assign HREADYOUTS = ~pend & (~dphase | readyout_ip);
   assign HRESPS     = dphase & resp_ip;

endmodule

// File: tb/tb_ahb_mtx_input_stage_hold.sv
// Directed bench for ahb_mtx_input_stage_hold: pass-through, hold/replay, data-phase stalls,
// ERROR propagation and reset while a transfer is held.
module tb_ahb_mtx_input_stage_hold;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned USER_W = 4;
   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   logic              HCLK;
   logic              HRESETn;
   logic              HSELS;
   logic [ADDR_W-1:0] HADDRS;
   logic [USER_W-1:0] HAUSERS;
   logic [1:0]        HTRANSS;
   logic              HWRITES;
   logic [2:0]        HSIZES;
   logic [2:0]        HBURSTS;
   logic [3:0]        HPROTS;
   logic [3:0]        HMASTERS;
   logic              HMASTLOCKS;
   logic              HREADYS;
   logic              active_ip;
   logic              readyout_ip;
   logic              resp_ip;
   logic              sel_ip;
   logic [ADDR_W-1:0] addr_ip;
   logic [USER_W-1:0] auser_ip;
   logic [1:0]        trans_ip;
   logic              write_ip;
   logic [2:0]        size_ip;
   logic [2:0]        burst_ip;
   logic [3:0]        prot_ip;
   logic [3:0]        master_ip;
   logic              mastlock_ip;
   logic              held_tran_ip;
   logic              HREADYOUTS;
   logic              HRESPS;

   int n_checks = 0;
   int n_pass   = 0;

   // Single master on the bus: the system HREADY it sees is its own HREADYOUTS.
   assign HREADYS = HREADYOUTS;

   ahb_mtx_input_stage_hold #(.ADDR_W(ADDR_W), .USER_W(USER_W)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HAUSERS(HAUSERS),
      .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
      .HPROTS(HPROTS), .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
      .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip),
      .sel_ip(sel_ip), .addr_ip(addr_ip), .auser_ip(auser_ip), .trans_ip(trans_ip),
      .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip),
      .master_ip(master_ip), .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip),
      .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic drive(input logic sel, input logic [1:0] trans, input logic [ADDR_W-1:0] addr,
                        input logic act, input logic rdy, input logic resp);
      HSELS       = sel;
      HTRANSS     = trans;
      HADDRS      = addr;
      active_ip   = act;
      readyout_ip = rdy;
      resp_ip     = resp;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESETn = 1'b0;
      HAUSERS = 4'h0; HWRITES = 1'b0; HSIZES = 3'd0; HBURSTS = 3'd0;
      HPROTS = 4'h0; HMASTERS = 4'h0; HMASTLOCKS = 1'b0;
      drive(1'b1, NONSEQ, 32'h0000_0ABC, 1'b0, 1'b0, 1'b1);
      #3;
      // 1. reset: live pass-through, ready, OKAY
      check("rst_hreadyout", 64'(HREADYOUTS), 64'd1);
      check("rst_hresp", 64'(HRESPS), 64'd0);
      check("rst_held_live", 64'(held_tran_ip), 64'd1);
      check("rst_addr_live", 64'(addr_ip), 64'h0000_0ABC);
      drive(1'b0, IDLE, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      check("rst_held_idle", 64'(held_tran_ip), 64'd0);
      step();
      HRESETn = 1'b1;

      // 2. granted, ready NONSEQ: zero added latency
      drive(1'b1, NONSEQ, 32'h0000_1000, 1'b1, 1'b1, 1'b0);
      #1;
      check("t2_addr", 64'(addr_ip), 64'h0000_1000);
      check("t2_held", 64'(held_tran_ip), 64'd1);
      check("t2_hready_a", 64'(HREADYOUTS), 64'd1);
      step();
      drive(1'b0, IDLE, 32'h0, 1'b1, 1'b1, 1'b0);
      #1;
      check("t2_hready_d", 64'(HREADYOUTS), 64'd1);
      check("t2_held_d", 64'(held_tran_ip), 64'd0);
      step();

      // 3. blocked SEQ held for three cycles, then issued when active_ip rises
      HSIZES = 3'd2; HWRITES = 1'b1; HMASTERS = 4'h5;
      drive(1'b1, SEQ, 32'h2000_0040, 1'b0, 1'b1, 1'b0);
      #1;
      check("t3_held_c0", 64'(held_tran_ip), 64'd1);
      check("t3_hready_c0", 64'(HREADYOUTS), 64'd1);
      step();
      HSIZES = 3'd0; HWRITES = 1'b0; HMASTERS = 4'h0;
      drive(1'b0, IDLE, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
      #1;
      check("t3_hready_c1", 64'(HREADYOUTS), 64'd0);
      check("t3_addr_c1", 64'(addr_ip), 64'h2000_0040);
      check("t3_trans_c1", 64'(trans_ip), 64'(SEQ));
      check("t3_sel_c1", 64'(sel_ip), 64'd1);
      check("t3_size_c1", 64'(size_ip), 64'd2);
      check("t3_write_c1", 64'(write_ip), 64'd1);
      check("t3_master_c1", 64'(master_ip), 64'h5);
      check("t3_held_c1", 64'(held_tran_ip), 64'd1);
      step();
      #1;
      check("t3_hready_c2", 64'(HREADYOUTS), 64'd0);
      check("t3_addr_c2", 64'(addr_ip), 64'h2000_0040);
      step();
      active_ip = 1'b1;
      #1;
      check("t3_hready_c3", 64'(HREADYOUTS), 64'd0);
      check("t3_held_c3", 64'(held_tran_ip), 64'd1);
      check("t3_addr_c3", 64'(addr_ip), 64'h2000_0040);
      step();
      #1;
      check("t3_hready_c4", 64'(HREADYOUTS), 64'd1);
      check("t3_held_c4", 64'(held_tran_ip), 64'd0);
      check("t3_addr_live", 64'(addr_ip), 64'hDEAD_BEEF);
      step();

      // 4. data-phase stall of two cycles; next NONSEQ accepted on the completing edge
      drive(1'b1, NONSEQ, 32'h0000_3000, 1'b1, 1'b1, 1'b0);
      #1;
      check("t4_held_a", 64'(held_tran_ip), 64'd1);
      step();
      drive(1'b1, NONSEQ, 32'h0000_3004, 1'b1, 1'b0, 1'b0);
      #1;
      check("t4_hready_s1", 64'(HREADYOUTS), 64'd0);
      check("t4_held_s1", 64'(held_tran_ip), 64'd0);
      step();
      #1;
      check("t4_hready_s2", 64'(HREADYOUTS), 64'd0);
      step();
      readyout_ip = 1'b1;
      #1;
      check("t4_hready_done", 64'(HREADYOUTS), 64'd1);
      check("t4_held_next", 64'(held_tran_ip), 64'd1);
      check("t4_addr_next", 64'(addr_ip), 64'h0000_3004);
      step();
      drive(1'b0, IDLE, 32'h0, 1'b1, 1'b1, 1'b0);
      #1;
      check("t4_hready_next_d", 64'(HREADYOUTS), 64'd1);
      check("t4_held_idle", 64'(held_tran_ip), 64'd0);
      step();

      // 5. two-cycle ERROR response passes through
      drive(1'b1, NONSEQ, 32'h0000_4000, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b0, IDLE, 32'h0, 1'b1, 1'b0, 1'b1);
      #1;
      check("t5_hresp_1", 64'(HRESPS), 64'd1);
      check("t5_hready_1", 64'(HREADYOUTS), 64'd0);
      step();
      readyout_ip = 1'b1;
      #1;
      check("t5_hresp_2", 64'(HRESPS), 64'd1);
      check("t5_hready_2", 64'(HREADYOUTS), 64'd1);
      step();
      #1;
      check("t5_hresp_nodp", 64'(HRESPS), 64'd0);
      check("t5_hready_nodp", 64'(HREADYOUTS), 64'd1);
      step();

      // HSELS low with NONSEQ: no request, no data phase
      drive(1'b0, NONSEQ, 32'h0000_5000, 1'b1, 1'b1, 1'b0);
      #1;
      check("unsel_held", 64'(held_tran_ip), 64'd0);
      step();
      drive(1'b0, IDLE, 32'h0, 1'b1, 1'b0, 1'b1);
      #1;
      check("unsel_hready", 64'(HREADYOUTS), 64'd1);
      check("unsel_hresp", 64'(HRESPS), 64'd0);
      step();

      // 6. reset while a transfer is held
      drive(1'b1, NONSEQ, 32'h0000_6000, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b1, NONSEQ, 32'h0000_7000, 1'b0, 1'b1, 1'b0);
      #1;
      check("t6_hready_pend", 64'(HREADYOUTS), 64'd0);
      check("t6_addr_pend", 64'(addr_ip), 64'h0000_6000);
      #1;
      HRESETn = 1'b0;
      HTRANSS = IDLE;
      #1;
      check("t6_held_rst", 64'(held_tran_ip), 64'd0);
      check("t6_hready_rst", 64'(HREADYOUTS), 64'd1);
      check("t6_addr_rst", 64'(addr_ip), 64'h0000_7000);
      step();
      HRESETn = 1'b1;
      #1;
      check("t6_held_rel", 64'(held_tran_ip), 64'd0);
      step();
      check("t6_held_after", 64'(held_tran_ip), 64'd0);
      check("t6_hready_after", 64'(HREADYOUTS), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
